// File: rtl/id_exe_skid_stage.sv
// id_exe_skid_stage
//   Two-entry valid/ready pipeline stage between decode and execute. It carries
//   {pc, payload} from the decoder to the ALU. The head entry lives in the main
//   register. A second entry parks in the skid register while execute stalls.
//   in_ready is decoded from registered state only, so the stage has no
//   combinational path from out_ready to in_ready.
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   rst         : synchronous active-high reset, has priority over everything
//   flush       : kills held entries and any entry offered this cycle
//   in_valid    : decode presents an entry
//   in_ready    : stage can accept (state != FULL)
//   in_pc       : PC of the offered entry
//   in_payload  : control/data payload of the offered entry
//   out_valid   : head entry present (state != EMPTY)
//   out_ready   : execute consumes the head entry
//   out_pc      : PC of the head entry
//   out_payload : payload of the head entry
//   occupancy   : number of held entries, 0..2 (equals the state encoding)
module id_exe_skid_stage #(
    parameter int PC_W        = 32,
    parameter int PAYLOAD_W   = 104,
    parameter int ZERO_BUBBLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_W-1:0]      out_pc,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [1:0]           occupancy
);

    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    // The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;
    entry_t main_q, main_nxt;
    entry_t skid_q, skid_nxt;
    entry_t in_entry;

    logic accept;
    logic pop;

    assign in_entry  = '{pc: in_pc, payload: in_payload};
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign occupancy = state;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

    // Input data is only captured on accept, so X on in_* is harmless otherwise.
    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            // A pop in this cycle is still taken by execute. Nothing else survives.
            state_nxt = EMPTY;
            main_nxt  = '0;
            skid_nxt  = '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt = ONE;
                        main_nxt  = in_entry;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_nxt = in_entry;
                    end else if (accept) begin
                        state_nxt = FULL;
                        skid_nxt  = in_entry;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can move the stage.
                    if (pop) begin
                        state_nxt = ONE;
                        main_nxt  = skid_q;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    generate
        if (ZERO_BUBBLE != 0) begin : g_zero_bubble
            // An invalid head reads as all-zero, which execute treats as a NOP.
            assign out_pc      = out_valid ? main_q.pc      : '0;
            assign out_payload = out_valid ? main_q.payload : '0;
        end else begin : g_stale
            assign out_pc      = main_q.pc;
            assign out_payload = main_q.payload;
        end
    endgenerate

endmodule

// File: tb/tb_id_exe_skid_stage.sv
module tb_id_exe_skid_stage;

    localparam int PC_W      = 32;
    localparam int PAYLOAD_W = 104;

    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic [PAYLOAD_W-1:0] payload;
    } ent_t;

    logic clk = 1'b0;
    logic rst, flush, in_valid, out_ready;
    logic [PC_W-1:0]      in_pc;
    logic [PAYLOAD_W-1:0] in_payload;

    logic                 zb_in_ready, zb_out_valid;
    logic [PC_W-1:0]      zb_out_pc;
    logic [PAYLOAD_W-1:0] zb_out_payload;
    logic [1:0]           zb_occ;

    logic                 st_in_ready, st_out_valid;
    logic [PC_W-1:0]      st_out_pc;
    logic [PAYLOAD_W-1:0] st_out_payload;
    logic [1:0]           st_occ;

    int errors = 0;
    int checks = 0;

    // Reference model: a FIFO of at most two entries, plus the last head seen.
    // The last head is what a non-zeroing stage keeps showing once it drains.
    ent_t q[$];
    ent_t stale;

    always #5 clk = ~clk;

    id_exe_skid_stage #(.PC_W(PC_W), .PAYLOAD_W(PAYLOAD_W), .ZERO_BUBBLE(1)) dut_zb (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(zb_in_ready),
        .in_pc(in_pc), .in_payload(in_payload),
        .out_valid(zb_out_valid), .out_ready(out_ready),
        .out_pc(zb_out_pc), .out_payload(zb_out_payload),
        .occupancy(zb_occ)
    );

    id_exe_skid_stage #(.PC_W(PC_W), .PAYLOAD_W(PAYLOAD_W), .ZERO_BUBBLE(0)) dut_st (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(st_in_ready),
        .in_pc(in_pc), .in_payload(in_payload),
        .out_valid(st_out_valid), .out_ready(out_ready),
        .out_pc(st_out_pc), .out_payload(st_out_payload),
        .occupancy(st_occ)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic iv,
                         input logic [PC_W-1:0] pc, input logic ordy);
        rst        = r;
        flush      = f;
        in_valid   = iv;
        out_ready  = ordy;
        in_pc      = pc;
        in_payload = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // One clock: the model advances on the edge, then both DUTs are checked 1ns later.
    task automatic cyc();
        bit acc, pp;
        ent_t e;
        @(posedge clk);
        if (rst || flush) begin
            q.delete();
            stale = '0;
        end else begin
            acc = in_valid && (q.size() < 2);
            pp  = (q.size() > 0) && out_ready;
            e   = '{pc: in_pc, payload: in_payload};
            if (pp)  void'(q.pop_front());
            if (acc) q.push_back(e);
            if (q.size() > 0) stale = q[0];
        end
        #1;
        chk("zb_out_valid", zb_out_valid, q.size() > 0);
        chk("zb_in_ready",  zb_in_ready,  q.size() < 2);
        chk("zb_occupancy", zb_occ, q.size());
        chk("zb_out_pc",      zb_out_pc,      q.size() > 0 ? q[0].pc      : '0);
        chk("zb_out_payload", zb_out_payload, q.size() > 0 ? q[0].payload : '0);
        chk("st_out_valid", st_out_valid, q.size() > 0);
        chk("st_in_ready",  st_in_ready,  q.size() < 2);
        chk("st_occupancy", st_occ, q.size());
        chk("st_out_pc",      st_out_pc,      q.size() > 0 ? q[0].pc      : stale.pc);
        chk("st_out_payload", st_out_payload, q.size() > 0 ? q[0].payload : stale.payload);
    endtask

    initial begin
        stale = '0;
        drive(1, 0, 1, 32'h0, 1);

        // Reset with in_valid high: the stage comes up empty and zeroed.
        cyc();
        cyc();
        chk("rst_out_pc_const", zb_out_pc, 32'h0);
        chk("rst_st_payload_const", st_out_payload, '0);

        // Streaming: one entry per cycle, occupancy stays at 1.
        drive(0, 0, 1, 32'h100, 1); cyc();
        chk("stream_pc0", zb_out_pc, 32'h100);
        drive(0, 0, 1, 32'h104, 1); cyc();
        chk("stream_pc1", zb_out_pc, 32'h104);
        drive(0, 0, 1, 32'h108, 1); cyc();
        chk("stream_pc2", zb_out_pc, 32'h108);
        chk("stream_occ", zb_occ, 2'd1);
        drive(0, 0, 0, 32'h0, 1); cyc();   // drain: ZB=0 copy keeps 0x108

        // Backpressure: fill both entries, then 0x208 waits until space frees.
        drive(0, 0, 1, 32'h200, 0); cyc();
        drive(0, 0, 1, 32'h204, 0); cyc();
        chk("bp_full_occ", zb_occ, 2'd2);
        chk("bp_full_ready", zb_in_ready, 1'b0);
        drive(0, 0, 1, 32'h208, 0); cyc();
        drive(0, 0, 1, 32'h208, 1); cyc();
        chk("bp_second_head", zb_out_pc, 32'h204);
        drive(0, 0, 1, 32'h208, 1); cyc();
        chk("bp_third_head", zb_out_pc, 32'h208);
        drive(0, 0, 0, 32'h0, 1); cyc();

        // Flush while full with a new offer: everything is dropped.
        drive(0, 0, 1, 32'h2f0, 0); cyc();
        drive(0, 0, 1, 32'h2f4, 0); cyc();
        drive(0, 1, 1, 32'h300, 0); cyc();
        chk("flush_occ", zb_occ, 2'd0);
        chk("flush_st_payload", st_out_payload, '0);
        drive(0, 0, 0, 32'h0, 1); cyc();
        cyc();

        // Reset mid-operation while full and out_ready high.
        drive(0, 0, 1, 32'h400, 0); cyc();
        drive(0, 0, 1, 32'h404, 0); cyc();
        drive(1, 0, 1, 32'h408, 1); cyc();
        chk("rstmid_valid", zb_out_valid, 1'b0);
        drive(0, 0, 0, 32'h0, 1); cyc();
        cyc();

        // Randomised traffic, with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
